// File: rtl/march_c_controller.sv
// March C- memory self-test controller.
// Sequences a shared up/down address generator and a single-port memory
// through the six March C- elements, comparing every read one cycle later.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; status from the previous run is held
// SETUP | one cycle: reset (up) or preset (down) the address generator
// OP    | one memory operation per cycle for the current element
// DRAIN | one cycle so the final read can be compared
// DONE  | one cycle with done=1, then back to IDLE
module march_c_controller #(
    parameter int AD_W = 4,
    parameter int DW   = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            carry,
    input  logic [AD_W-1:0] addr,
    input  logic [DW-1:0]   rdata,
    output logic            ag_reset,
    output logic            ag_preset,
    output logic            ag_en,
    output logic            ag_up_down,
    output logic            mem_we,
    output logic            mem_re,
    output logic [DW-1:0]   wdata,
    output logic            busy,
    output logic            done,
    output logic            fail,
    output logic [AD_W-1:0] fail_addr,
    output logic [2:0]      fail_elem
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        OP    = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state, state_n;
    logic [2:0]      elem, elem_n;
    logic            op_idx, op_n;

    logic            cmp_valid;
    logic            cmp_bg;
    logic [AD_W-1:0] cmp_addr;
    logic [2:0]      cmp_elem;

    // Element table. E0 up(w0) E1 up(r0,w1) E2 up(r1,w0)
    // E3 down(r0,w1) E4 down(r1,w0) E5 up(r0).
    function automatic logic dir_up(input logic [2:0] e);
        return !(e == 3'd3 || e == 3'd4);
    endfunction

    function automatic logic last_op(input logic [2:0] e);
        return !(e == 3'd0 || e == 3'd5);
    endfunction

    function automatic logic is_read(input logic [2:0] e, input logic op);
        if (e == 3'd0) return 1'b0;
        if (e == 3'd5) return 1'b1;
        return !op;
    endfunction

    // Background of an op: data written, or data expected on a read.
    function automatic logic op_bg(input logic [2:0] e, input logic op);
        if (e == 3'd2 || e == 3'd4) return !op;
        if (e == 3'd1 || e == 3'd3) return op;
        return 1'b0;
    endfunction

    // Next-state decision; carry is only meaningful on an element's last op.
    always_comb begin
        state_n = state;
        elem_n  = elem;
        op_n    = op_idx;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = SETUP;
                    elem_n  = 3'd0;
                end
            end
            SETUP: begin
                state_n = OP;
                op_n    = 1'b0;
            end
            OP: begin
                if (op_idx == last_op(elem)) begin
                    op_n = 1'b0;
                    if (carry) begin
                        if (elem == 3'd5) begin
                            state_n = DRAIN;
                        end else begin
                            state_n = SETUP;
                            elem_n  = elem + 3'd1;
                        end
                    end
                end else begin
                    op_n = 1'b1;
                end
            end
            DRAIN:   state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // FSM state, registered outputs derived from the next state, and the read-compare pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            elem       <= 3'd0;
            op_idx     <= 1'b0;
            ag_reset   <= 1'b0;
            ag_preset  <= 1'b0;
            ag_en      <= 1'b0;
            ag_up_down <= 1'b0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            wdata      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_elem  <= 3'd0;
            cmp_valid  <= 1'b0;
            cmp_bg     <= 1'b0;
            cmp_addr   <= '0;
            cmp_elem   <= 3'd0;
        end else begin
            state  <= state_n;
            elem   <= elem_n;
            op_idx <= op_n;

            busy       <= (state_n == SETUP) || (state_n == OP) || (state_n == DRAIN);
            done       <= (state_n == DONE);
            ag_reset   <= (state_n == SETUP) && dir_up(elem_n);
            ag_preset  <= (state_n == SETUP) && !dir_up(elem_n);
            ag_en      <= (state_n == OP) && (op_n == last_op(elem_n));
            ag_up_down <= (state_n == OP) && dir_up(elem_n);
            mem_re     <= (state_n == OP) && is_read(elem_n, op_n);
            mem_we     <= (state_n == OP) && !is_read(elem_n, op_n);
            wdata      <= ((state_n == OP) && !is_read(elem_n, op_n)) ?
                          {DW{op_bg(elem_n, op_n)}} : '0;

            // The read issued this cycle returns data next cycle.
            cmp_valid <= mem_re;
            if (mem_re) begin
                cmp_bg   <= op_bg(elem, op_idx);
                cmp_addr <= addr;
                cmp_elem <= elem;
            end

            if (state == IDLE && start) begin
                fail      <= 1'b0;
                fail_addr <= '0;
                fail_elem <= 3'd0;
            end else if (cmp_valid && (rdata != {DW{cmp_bg}}) && !fail) begin
                fail      <= 1'b1;
                fail_addr <= cmp_addr;
                fail_elem <= cmp_elem;
            end
        end
    end

endmodule

// File: tb/tb_march_c_controller.sv
// Bench for march_c_controller: address generator + faulty memory model,
// abstract March C- reference, scoreboard popped on each done pulse.
module tb_march_c_controller;

    localparam int AD_W   = 4;
    localparam int DW     = 8;
    localparam int NW     = 1 << AD_W;
    localparam int RUN_LEN = 10 * NW + 7;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            carry;
    logic [AD_W-1:0] ag_addr = '0;
    logic [DW-1:0]   rdata = '0;
    logic            ag_reset, ag_preset, ag_en, ag_up_down;
    logic            mem_we, mem_re;
    logic [DW-1:0]   wdata;
    logic            busy, done, fail;
    logic [AD_W-1:0] fail_addr;
    logic [2:0]      fail_elem;

    int n_cmp = 0;
    int n_err = 0;

    // Fault configuration shared by the memory model and the reference.
    logic sa_en = 1'b0, sa_val = 1'b0, dis_en = 1'b0;
    int   sa_addr = 0, sa_bit = 0, dis_addr = 0;

    typedef struct {
        logic f;
        int   fa;
        int   fe;
    } exp_t;
    exp_t exp_q[$];

    logic [DW-1:0] mem [NW];

    int busy_cnt = 0, we_cnt = 0, re_cnt = 0, en_cnt = 0, setup_cnt = 0;
    logic prev_done = 1'b0;

    march_c_controller #(.AD_W(AD_W), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .carry      (carry),
        .addr       (ag_addr),
        .rdata      (rdata),
        .ag_reset   (ag_reset),
        .ag_preset  (ag_preset),
        .ag_en      (ag_en),
        .ag_up_down (ag_up_down),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .fail_addr  (fail_addr),
        .fail_elem  (fail_elem)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Stuck-at fault on one bit of one cell; read-disturb flips bit 0 of
    // one cell whenever it is read while counting down.
    function automatic logic [DW-1:0] apply_fault(input logic [DW-1:0] v, input int a, input logic up);
        logic [DW-1:0] r;
        r = v;
        if (sa_en && a == sa_addr) r[sa_bit] = sa_val;
        if (dis_en && a == dis_addr && !up) r[0] = ~r[0];
        return r;
    endfunction

    // Reference: walk March C- over an array and record the first failure.
    function automatic exp_t model_run();
        exp_t          res;
        logic [DW-1:0] m [NW];
        logic [DW-1:0] bg, v;
        int            a, code;
        // op code: 0=w0 1=w1 2=r0 3=r1
        int            ops [6][2] = '{'{0, 0}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, 0}};
        int            nops [6]   = '{1, 2, 2, 2, 2, 1};
        logic          up [6]     = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        res.f = 1'b0; res.fa = 0; res.fe = 0;
        for (int i = 0; i < NW; i++) m[i] = '0;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < NW; k++) begin
                a = up[e] ? k : NW - 1 - k;
                for (int o = 0; o < nops[e]; o++) begin
                    code = ops[e][o];
                    bg = (code % 2 == 1) ? {DW{1'b1}} : '0;
                    if (code < 2) begin
                        m[a] = bg;
                    end else begin
                        v = apply_fault(m[a], a, up[e]);
                        if (v != bg && !res.f) begin
                            res.f = 1'b1; res.fa = a; res.fe = e;
                        end
                    end
                end
            end
        end
        return res;
    endfunction

    // Address generator and memory under test.
    assign carry = ag_en && (ag_up_down ? (ag_addr == {AD_W{1'b1}}) : (ag_addr == '0));

    always @(posedge clk) begin
        if (ag_reset)       ag_addr <= '0;
        else if (ag_preset) ag_addr <= {AD_W{1'b1}};
        else if (ag_en)     ag_addr <= ag_up_down ? ag_addr + 1'b1 : ag_addr - 1'b1;
        if (mem_we) mem[ag_addr] <= wdata;
        if (mem_re) rdata <= apply_fault(mem[ag_addr], int'(ag_addr), ag_up_down);
    end

    // Monitor: per-cycle protocol checks, per-run totals popped at done.
    always @(negedge clk) begin
        if (reset) begin
            busy_cnt = 0; we_cnt = 0; re_cnt = 0; en_cnt = 0; setup_cnt = 0;
            prev_done = 1'b0;
        end else begin
            if (busy) begin
                check("strobe_onehot", $countones({mem_we, mem_re, ag_reset, ag_preset}) <= 1, 1);
                busy_cnt++;
            end
            if (ag_reset || ag_preset) begin
                check($sformatf("setup%0d_preset", setup_cnt), ag_preset,
                      (setup_cnt == 3 || setup_cnt == 4));
                check($sformatf("setup%0d_reset", setup_cnt), ag_reset,
                      !(setup_cnt == 3 || setup_cnt == 4));
                setup_cnt++;
            end
            if (mem_we || mem_re) begin
                check($sformatf("updown_e%0d", setup_cnt - 1), ag_up_down,
                      !(setup_cnt - 1 == 3 || setup_cnt - 1 == 4));
            end
            if (mem_we) we_cnt++;
            if (mem_re) re_cnt++;
            if (ag_en)  en_cnt++;
            if (done) begin
                check("done_single_cycle", prev_done, 0);
                check("busy_at_done", busy, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t ex;
                    ex = exp_q.pop_front();
                    check("busy_cycles", busy_cnt, RUN_LEN);
                    check("we_count", we_cnt, 5 * NW);
                    check("re_count", re_cnt, 5 * NW);
                    check("ag_en_count", en_cnt, 6 * NW);
                    check("fail", fail, ex.f);
                    check("fail_addr", fail_addr, ex.f ? ex.fa : 0);
                    check("fail_elem", fail_elem, ex.f ? ex.fe : 0);
                end
                busy_cnt = 0; we_cnt = 0; re_cnt = 0; en_cnt = 0; setup_cnt = 0;
            end
            prev_done = done;
        end
    end

    task automatic check_all_zero(input string name);
        check(name, {ag_reset, ag_preset, ag_en, ag_up_down, mem_we, mem_re, wdata,
                     busy, done, fail, fail_addr, fail_elem}, 0);
    endtask

    task automatic set_faults(input logic s_en, input int s_a, input int s_b, input logic s_v,
                              input logic d_en, input int d_a);
        sa_en = s_en; sa_addr = s_a; sa_bit = s_b; sa_val = s_v;
        dis_en = d_en; dis_addr = d_a;
    endtask

    // One complete run; optional extra start pulse at a given busy cycle.
    task automatic run_march(input int repulse);
        bit got;
        exp_q.push_back(model_run());
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        got = 0;
        for (int c = 1; c < 400; c++) begin
            start = (repulse > 0 && c == repulse);
            @(negedge clk);
            if (done) begin got = 1; break; end
        end
        start = 1'b0;
        if (!got) begin
            check("done_timeout", 0, 1);
            exp_q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        bit seen;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset_outputs");
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("idle_outputs");

        // Fault-free run.
        set_faults(0, 0, 0, 0, 0, 0);
        run_march(0);

        // Stuck-at-0, bit 0, address 5: first seen in E2.
        set_faults(1, 5, 0, 0, 0, 0);
        run_march(0);

        // Two faults: address 2 (seen in E1) and address 9 (seen in E3).
        set_faults(1, 2, 3, 1, 1, 9);
        run_march(0);

        // Reset during E2 OP, then a clean run.
        set_faults(1, 7, 1, 1, 0, 0);
        exp_q.push_back(model_run());
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        seen = 0;
        for (int c = 0; c < 300; c++) begin
            if (setup_cnt == 3 && (mem_we || mem_re)) begin seen = 1; break; end
            @(negedge clk);
        end
        check("reached_e2", seen, 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 check_all_zero("midrun_reset_outputs");
        @(negedge clk);
        @(negedge clk); reset = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        check_all_zero("after_reset_idle");
        set_faults(0, 0, 0, 0, 0, 0);
        run_march(0);

        // Start re-pulsed mid-run must be ignored.
        run_march(50);

        // Randomised fault placements.
        for (int r = 0; r < 6; r++) begin
            set_faults($urandom_range(0, 1), $urandom_range(0, NW - 1), $urandom_range(0, DW - 1),
                       $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, NW - 1));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_march($urandom_range(0, 1) ? $urandom_range(2, RUN_LEN) : 0);
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/march_c_controller.md
MARCH_C_CONTROLLER -- requirements
Module: march_c_controller

Interface
REQ-001 The block SHALL have parameter AD_W, default 4, meaning the address width of the shared address generator and memory under test.
REQ-002 The block SHALL have parameter DW, default 8, meaning the memory data width.
REQ-003 The block SHALL have port clk, input, 1, the system clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, run request, sampled only in IDLE.
REQ-006 The block SHALL have port carry, input, 1, terminal-address flag from the address generator, valid combinationally while ag_en is high.
REQ-007 The block SHALL have port addr, input, AD_W, the current address-generator output.
REQ-008 The block SHALL have port rdata, input, DW, memory read data, valid one cycle after mem_re.
REQ-009 The block SHALL have ports ag_reset, ag_preset, ag_en, ag_up_down: output, 1 each, address-generator controls.
REQ-010 The block SHALL have ports mem_we, mem_re: output, 1 each, memory write and read strobes.
REQ-011 The block SHALL have port wdata, output, DW, memory write data.
REQ-012 The block SHALL have ports busy, done, fail: output, 1 each, run status.
REQ-013 The block SHALL have ports fail_addr, output, AD_W, and fail_elem, output, 3: first-failure address and March element index.

Function
REQ-014 The block SHALL execute March C-, elements 0..5: E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up(r0).
REQ-015 Background 0 SHALL be all-zeros DW; background 1 SHALL be all-ones DW.
REQ-016 States SHALL be IDLE, SETUP, OP, DRAIN, DONE.
REQ-017 IDLE: start=1 -> SETUP with elem=0; fail, fail_addr, fail_elem cleared on the same edge; start=0 -> stay.
REQ-018 SETUP, exactly one cycle: ag_reset=1 for up elements, ag_preset=1 for down elements; then OP with op_idx=0.
REQ-019 OP, one memory operation per cycle: read op -> mem_re=1; write op -> mem_we=1 with wdata equal to that op's background.
REQ-020 In OP, ag_up_down SHALL equal the element direction in every cycle, and ag_en=1 only in the cycle of the element's last op; otherwise op_idx increments.
REQ-021 On the last op with carry=0, op_idx SHALL return to 0.
REQ-022 On the last op with carry=1: elem<5 -> SETUP with elem+1; elem=5 -> DRAIN.
REQ-023 DRAIN SHALL last one cycle to complete the final compare, then go to DONE.
REQ-024 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-025 busy SHALL be 1 in SETUP, OP and DRAIN, and 0 in IDLE and DONE.
REQ-026 Compare pipeline: each read SHALL register expected data, addr and elem; in the next cycle rdata SHALL be compared against the registered expected data.
REQ-027 On a mismatch with fail=0: fail=1 (sticky) and fail_addr/fail_elem captured from the pipeline registers; later mismatches SHALL NOT overwrite them, and the run continues to completion.
REQ-028 Run length SHALL be 10*2^AD_W + 7 busy cycles: 6 SETUP + 10*2^AD_W OP + 1 DRAIN.
REQ-029 start while busy or in DONE SHALL be ignored.
REQ-030 At most one of mem_we, mem_re, ag_reset, ag_preset SHALL be high in any cycle.

Reset
REQ-031 reset=1 SHALL force IDLE on the next edge from any state, including mid-run, overriding start.
REQ-032 During and after reset, all outputs SHALL be 0 (wdata, fail_addr and fail_elem included), and the compare pipeline SHALL be cleared so no stale read can set fail.

Verification
REQ-033 AD_W=4, DW=8, fault-free memory, start pulse -> busy for 167 cycles, 80 mem_we, 80 mem_re, single-cycle done, fail=0.
REQ-034 Stuck-at-0 on bit 0 at address 5 -> fail=1 with fail_addr=5, fail_elem=2, and done still asserted after 167 busy cycles.
REQ-035 Direction check -> ag_preset=1 in the SETUP cycle of E3 and E4 only, ag_reset=1 in the SETUP cycle of E0, E1, E2 and E5, and ag_up_down=0 throughout E3/E4 OP cycles.
REQ-036 reset=1 during E2 OP -> all outputs 0 on the next cycle; a subsequent start runs the full 167 cycles with fail=0.
REQ-037 start re-pulsed at busy cycle 50 -> ignored; exactly one done pulse, at the expected cycle.
REQ-038 Two faults, at address 2 (E1) and address 9 (E3) -> fail_addr=2, fail_elem=1 retained at done.
